// File: rtl/dds_hop_ctrl.sv
// -----------------------------------------------------------------------------
// dds_hop_ctrl
//
// Frequency-hop sequencer for the DDS carrier generator that feeds the IQ/MSK
// modulator. A 4-entry table of phase-increment words is stepped through as a
// hop schedule. Each hop issues a DDS register write, waits SETTLE cycles for
// the DDS pipeline to produce a valid carrier, then holds mod_en high for the
// programmed dwell.
//
// Optional feature macro: DDS_HOP_PHASE_EN
//   Adds a 4 x 16-bit phase-offset table (written when cfg_phase_sel=1) and a
//   second LOAD cycle that writes {12'b0, phase[idx]} to DDS register 1.
//
// Parameters
//   PINC_W   phase-increment word width (DDS data bus)
//   DWELL_W  dwell counter width
//   SETTLE   DDS write-to-valid-carrier latency in cycles (>= 1)
//
// Ports
//   clk, rst_n         clock, synchronous active-low reset
//   cfg_we/addr/data   table write port, usable at any time
//   cfg_phase_sel      (DDS_HOP_PHASE_EN only) route writes to phase table
//   hop_len            active entries (0 -> 1, >4 -> 4)
//   dwell              mod_en cycles per hop (0 -> 1)
//   start / stop       begin hopping from entry 0 / abort to idle
//   dds_data/a/we      DDS register write port
//   mod_en             carrier valid, qualifies the modulator output
//   busy               high whenever not idle
//   hop_idx            table entry currently loaded
//   hop_strobe         pulses with each phase-increment write
// -----------------------------------------------------------------------------
module dds_hop_ctrl #(
  parameter int PINC_W  = 28,
  parameter int DWELL_W = 16,
  parameter int SETTLE  = 8
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               cfg_we,
  input  logic [1:0]         cfg_addr,
  input  logic [PINC_W-1:0]  cfg_data,
`ifdef DDS_HOP_PHASE_EN
  input  logic               cfg_phase_sel,
`endif
  input  logic [2:0]         hop_len,
  input  logic [DWELL_W-1:0] dwell,
  input  logic               start,
  input  logic               stop,
  output logic [PINC_W-1:0]  dds_data,
  output logic [4:0]         dds_a,
  output logic               dds_we,
  output logic               mod_en,
  output logic               busy,
  output logic [1:0]         hop_idx,
  output logic               hop_strobe
);

  localparam int SET_W = $clog2(SETTLE + 1);
  // One counter serves both the settle and the dwell phase.
  localparam int CNT_W = (DWELL_W > SET_W) ? DWELL_W : SET_W;
  localparam logic [PINC_W-1:0] PINC_RST0 = PINC_W'(13421772);

  typedef enum logic [2:0] {
    S_IDLE,
    S_LOAD,
    S_LOAD2,
    S_SETTLE,
    S_DWELL
  } state_t;

  state_t              r_state;
  state_t              w_next;
  logic [CNT_W-1:0]    r_cnt;
  logic [1:0]          r_idx;
  logic [PINC_W-1:0]   r_pinc [4];
`ifdef DDS_HOP_PHASE_EN
  logic [15:0]         r_phase [4];
`endif
  logic [PINC_W-1:0]   r_dds_data;
  logic [4:0]          r_dds_a;

  logic [2:0]          w_eff_len;
  logic [DWELL_W-1:0]  w_eff_dwell;
  logic [1:0]          w_idx_next;
  logic                w_cnt_zero;

  assign w_eff_len   = (hop_len == 3'd0) ? 3'd1 :
                       (hop_len > 3'd4)  ? 3'd4 : hop_len;
  assign w_eff_dwell = (dwell == '0) ? DWELL_W'(1) : dwell;
  // Compare in 3 bits so an entry count of 4 wraps index 3 back to 0.
  assign w_idx_next  = (({1'b0, r_idx} + 3'd1) == w_eff_len) ? 2'd0 : r_idx + 2'd1;
  assign w_cnt_zero  = (r_cnt == '0);

  // Table storage; writes are accepted in every state.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_pinc[0] <= PINC_RST0;
      for (int i = 1; i < 4; i++) r_pinc[i] <= '0;
`ifdef DDS_HOP_PHASE_EN
      for (int i = 0; i < 4; i++) r_phase[i] <= '0;
`endif
    end else if (cfg_we) begin
`ifdef DDS_HOP_PHASE_EN
      if (cfg_phase_sel) r_phase[cfg_addr] <= cfg_data[15:0];
      else               r_pinc[cfg_addr]  <= cfg_data;
`else
      r_pinc[cfg_addr] <= cfg_data;
`endif
    end
  end

  // State register, hop counter/index and held DDS bus values.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state    <= S_IDLE;
      r_cnt      <= '0;
      r_idx      <= 2'd0;
      r_dds_data <= '0;
      r_dds_a    <= 5'd0;
    end else begin
      r_state <= w_next;
      if (dds_we) begin
        r_dds_data <= dds_data;
        r_dds_a    <= dds_a;
      end
      case (r_state)
        S_IDLE: begin
          if (start && !stop) r_idx <= 2'd0;
        end
`ifdef DDS_HOP_PHASE_EN
        S_LOAD2: r_cnt <= CNT_W'(SETTLE - 1);
`else
        S_LOAD:  r_cnt <= CNT_W'(SETTLE - 1);
`endif
        S_SETTLE: begin
          // Dwell is sampled here, on entry to DWELL.
          if (w_cnt_zero) r_cnt <= CNT_W'(w_eff_dwell - DWELL_W'(1));
          else            r_cnt <= r_cnt - CNT_W'(1);
        end
        S_DWELL: begin
          // hop_len is sampled here; a stop on this edge keeps the index.
          if (w_cnt_zero) begin
            if (!stop) r_idx <= w_idx_next;
          end else begin
            r_cnt <= r_cnt - CNT_W'(1);
          end
        end
        default: ;
      endcase
    end
  end

  // Next state and DDS write port. The table is read combinationally in LOAD,
  // so a same-cycle cfg_we to that entry is only seen on the next visit.
  always_comb begin
    w_next     = r_state;
    dds_we     = 1'b0;
    hop_strobe = 1'b0;
    dds_data   = r_dds_data;
    dds_a      = r_dds_a;
    case (r_state)
      S_IDLE: begin
        if (start) w_next = S_LOAD;
      end
      S_LOAD: begin
        dds_we     = 1'b1;
        hop_strobe = 1'b1;
        dds_data   = r_pinc[r_idx];
        dds_a      = 5'd0;
`ifdef DDS_HOP_PHASE_EN
        w_next     = S_LOAD2;
`else
        w_next     = S_SETTLE;
`endif
      end
`ifdef DDS_HOP_PHASE_EN
      S_LOAD2: begin
        dds_we   = 1'b1;
        dds_data = PINC_W'(r_phase[r_idx]);
        dds_a    = 5'd1;
        w_next   = S_SETTLE;
      end
`endif
      S_SETTLE: begin
        if (w_cnt_zero) w_next = S_DWELL;
      end
      S_DWELL: begin
        if (w_cnt_zero) w_next = S_LOAD;
      end
      default: w_next = S_IDLE;
    endcase
    // stop overrides everything, including a same-cycle start.
    if (stop) w_next = S_IDLE;
  end

  assign mod_en  = (r_state == S_DWELL);
  assign busy    = (r_state != S_IDLE);
  assign hop_idx = r_idx;

endmodule

// File: tb/tb_dds_hop_ctrl.sv
`timescale 1ns/1ps
module tb_dds_hop_ctrl;
  localparam int PINC_W  = 28;
  localparam int DWELL_W = 16;
  localparam int SETTLE  = 8;
`ifdef DDS_HOP_PHASE_EN
  localparam int LW = 2;
`else
  localparam int LW = 1;
`endif

  logic              clk = 1'b0;
  logic              rst_n = 1'b0;
  logic              cfg_we = 1'b0;
  logic [1:0]        cfg_addr = 2'd0;
  logic [PINC_W-1:0] cfg_data = '0;
`ifdef DDS_HOP_PHASE_EN
  logic              cfg_phase_sel = 1'b0;
`endif
  logic [2:0]        hop_len = 3'd0;
  logic [DWELL_W-1:0] dwell = '0;
  logic              start = 1'b0;
  logic              stop = 1'b0;
  logic [PINC_W-1:0] dds_data;
  logic [4:0]        dds_a;
  logic              dds_we, mod_en, busy, hop_strobe;
  logic [1:0]        hop_idx;

  dds_hop_ctrl #(.PINC_W(PINC_W), .DWELL_W(DWELL_W), .SETTLE(SETTLE)) dut (
    .clk(clk), .rst_n(rst_n), .cfg_we(cfg_we), .cfg_addr(cfg_addr), .cfg_data(cfg_data),
`ifdef DDS_HOP_PHASE_EN
    .cfg_phase_sel(cfg_phase_sel),
`endif
    .hop_len(hop_len), .dwell(dwell), .start(start), .stop(stop),
    .dds_data(dds_data), .dds_a(dds_a), .dds_we(dds_we), .mod_en(mod_en),
    .busy(busy), .hop_idx(hop_idx), .hop_strobe(hop_strobe)
  );

  always #5 clk = ~clk;

  // cyc = number of rising edges so far; "cycle n" is the interval after edge n.
  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct { int cyc; logic [27:0] data; logic [4:0] a; logic [1:0] idx; logic strb; } wr_t;
  typedef struct { int cyc; int addr; logic [27:0] data; bit ph; } hist_t;

  wr_t   exp_q[$];
  hist_t hist[$];
  bit    exp_mod[int];
  bit    exp_busy[int];
  int    n_tests = 0;
  int    n_fail  = 0;
  bit    mon_en  = 1'b0;
  logic [27:0] last_data = '0;
  logic [4:0]  last_a = '0;
  logic [1:0]  last_idx = '0;

  task automatic check(input string name, input bit ok, input string msg);
    n_tests++;
    if (!ok) begin
      n_fail++;
      $display("FAIL %s: %s", name, msg);
    end
  endtask

  function automatic void add_hist(input int c, input int addr, input logic [27:0] d, input bit ph);
    hist_t h;
    h.cyc = c; h.addr = addr; h.data = d; h.ph = ph;
    hist.push_back(h);
  endfunction

  // Table contents as seen during cycle L: a write issued in cycle w is visible from w+1.
  function automatic logic [27:0] tbl_at(input int addr, input bit ph, input int L);
    logic [27:0] v = '0;
    foreach (hist[i])
      if (hist[i].cyc < L && hist[i].addr == addr && hist[i].ph == ph) v = hist[i].data;
    return v;
  endfunction

  function automatic void reset_hist(input int c);
    for (int i = 0; i < 4; i++) begin
      add_hist(c, i, (i == 0) ? 28'd13421772 : 28'd0, 1'b0);
      add_hist(c, i, 28'd0, 1'b1);
    end
  endfunction

  function automatic void push_wr(input int c, input logic [27:0] d, input logic [4:0] a,
                                  input int idx, input logic strb);
    wr_t e;
    e.cyc = c; e.data = d; e.a = a; e.idx = 2'(idx); e.strb = strb;
    exp_q.push_back(e);
  endfunction

  // Monitor: compares every cycle; pops the scoreboard whenever the DUT writes.
  always @(negedge clk) begin
    wr_t e;
    bit eb, em;
    if (mon_en) begin
      eb = exp_busy.exists(cyc) ? exp_busy[cyc] : 1'b0;
      em = exp_mod.exists(cyc)  ? exp_mod[cyc]  : 1'b0;
      check("busy", busy === eb, $sformatf("cycle %0d busy=%b expected %b", cyc, busy, eb));
      check("mod_en", mod_en === em, $sformatf("cycle %0d mod_en=%b expected %b", cyc, mod_en, em));
      if (dds_we === 1'b1) begin
        if (exp_q.size() == 0) begin
          check("dds_we", 1'b0, $sformatf("cycle %0d unexpected write data=%0d a=%0d", cyc, dds_data, dds_a));
        end else begin
          e = exp_q.pop_front();
          check("write", cyc == e.cyc && dds_data === e.data && dds_a === e.a &&
                hop_idx === e.idx && hop_strobe === e.strb,
                $sformatf("got cyc=%0d data=%0d a=%0d idx=%0d strb=%b, expected cyc=%0d data=%0d a=%0d idx=%0d strb=%b",
                          cyc, dds_data, dds_a, hop_idx, hop_strobe, e.cyc, e.data, e.a, e.idx, e.strb));
          last_data = e.data; last_a = e.a; last_idx = e.idx;
        end
      end else begin
        check("hold", dds_we === 1'b0 && hop_strobe === 1'b0 && dds_data === last_data &&
              dds_a === last_a && hop_idx === last_idx,
              $sformatf("cycle %0d we=%b strb=%b data=%0d a=%0d idx=%0d, expected 0 0 %0d %0d %0d",
                        cyc, dds_we, hop_strobe, dds_data, dds_a, hop_idx, last_data, last_a, last_idx));
      end
    end
  end

  task automatic cfg_write(input int addr, input logic [27:0] data, input bit ph);
    @(posedge clk); #1;
    cfg_we = 1'b1; cfg_addr = 2'(addr); cfg_data = data;
`ifdef DDS_HOP_PHASE_EN
    cfg_phase_sel = ph;
`endif
    add_hist(cyc, addr, ph ? {12'd0, data[15:0]} : data, ph);
    @(posedge clk); #1;
    cfg_we = 1'b0;
`ifdef DDS_HOP_PHASE_EN
    cfg_phase_sel = 1'b0;
`endif
  endtask

  // One hop run: start in cycle k, stop (or reset) asserted in cycle k+nstop.
  // Optional table write to entry waddr during cycle k+woff.
  task automatic run(input int len, input int dw, input int nstop, input bit use_rst,
                     input bit wr, input int woff, input int waddr, input logic [27:0] wdata);
    int k, c, el, ed, p, idx;
    @(posedge clk); #1;
    k = cyc; c = k + nstop;
    hop_len = 3'(len); dwell = DWELL_W'(dw); start = 1'b1;
    if (wr) add_hist(k + woff, waddr, wdata, 1'b0);
    el  = (len == 0) ? 1 : ((len > 4) ? 4 : len);
    ed  = (dw == 0) ? 1 : dw;
    p   = LW + SETTLE + ed;
    idx = 0;
    for (int L = k + 1; L <= c; L += p) begin
      push_wr(L, tbl_at(idx, 1'b0, L), 5'd0, idx, 1'b1);
      if (LW == 2 && L + 1 <= c) push_wr(L + 1, tbl_at(idx, 1'b1, L + 1), 5'd1, idx, 1'b0);
      for (int d = 0; d < ed; d++)
        if (L + LW + SETTLE + d <= c) exp_mod[L + LW + SETTLE + d] = 1'b1;
      idx = (idx + 1 == el) ? 0 : idx + 1;
    end
    for (int b = k + 1; b <= c; b++) exp_busy[b] = 1'b1;
    for (int t = k + 1; t <= c + 1; t++) begin
      @(posedge clk); #1;
      // start pulses while busy must be ignored; at cycle c stop/reset wins.
      start    = (t <= c) ? ($urandom_range(0, 3) == 0) : 1'b0;
      cfg_we   = (wr && t == k + woff);
      cfg_addr = 2'(waddr);
      cfg_data = wdata;
      stop     = (!use_rst && t == c);
      rst_n    = !(use_rst && (t == c || t == c + 1));
      if (use_rst && t == c) reset_hist(c);
      if (use_rst && t == c + 1) begin
        last_data = '0; last_a = '0; last_idx = '0;
      end
    end
    @(posedge clk); #1;
    start = 1'b0; stop = 1'b0; cfg_we = 1'b0; rst_n = 1'b1;
    repeat (2) @(posedge clk);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation exceeded time limit at cycle %0d", cyc);
    $fatal(1, "watchdog");
  end

  initial begin
    int n, wo;
    reset_hist(-1000);
    rst_n = 1'b0; start = 1'b1;
    repeat (3) begin
      @(posedge clk); #1;
      mon_en = 1'b1;
      check("reset_out", {dds_data, dds_a, dds_we, mod_en, busy, hop_idx, hop_strobe} === '0,
            $sformatf("data=%0d a=%0d we=%b mod=%b busy=%b idx=%0d strb=%b, expected all 0",
                      dds_data, dds_a, dds_we, mod_en, busy, hop_idx, hop_strobe));
    end
    rst_n = 1'b1; start = 1'b0;

    // Default table entry 0 after reset.
    run(1, 3, 20, 1'b0, 1'b0, 0, 0, '0);

    // Three-entry hop.
    for (int i = 0; i < 4; i++) cfg_write(i, 28'(100 * (i + 1)), 1'b0);
    run(3, 5, 45, 1'b0, 1'b0, 0, 0, '0);

    // Degenerate hop_len/dwell.
    run(0, 0, 32, 1'b0, 1'b0, 0, 0, '0);

    // Stop mid-dwell, then start+stop together, then restart from entry 0.
    run(2, 5, 12, 1'b0, 1'b0, 0, 0, '0);
    @(posedge clk); #1; start = 1'b1; stop = 1'b1;
    @(posedge clk); #1; start = 1'b0; stop = 1'b0;
    repeat (2) @(posedge clk);
    run(4, 2, 30, 1'b0, 1'b0, 0, 0, '0);

    // Same-cycle table write to entry 1 during its LOAD.
    run(2, 2, 40, 1'b0, 1'b1, 1 + LW + SETTLE + 2, 1, 28'd777);

`ifdef DDS_HOP_PHASE_EN
    cfg_write(0, 28'h0004000, 1'b1);
    run(1, 3, 30, 1'b0, 1'b0, 0, 0, '0);
`endif

    // Randomized runs.
    repeat (12) begin
      n = $urandom_range(0, 2);
      for (int i = 0; i < n; i++) cfg_write($urandom_range(0, 3), 28'($urandom), 1'b0);
`ifdef DDS_HOP_PHASE_EN
      cfg_write($urandom_range(0, 3), 28'($urandom), 1'b1);
`endif
      n  = $urandom_range(3, 60);
      wo = $urandom_range(1, n);
      run($urandom_range(0, 7), $urandom_range(0, 6), n, 1'b0,
          1'($urandom_range(0, 1)), wo, $urandom_range(0, 3), 28'($urandom));
    end

    // Reset mid-run, then confirm the table came back to its reset contents.
    run(2, 4, 20, 1'b1, 1'b0, 0, 0, '0);
    run(1, 1, 15, 1'b0, 1'b0, 0, 0, '0);

    repeat (5) @(posedge clk);
    #1;
    check("drain", exp_q.size() == 0, $sformatf("%0d expected writes never seen, expected 0", exp_q.size()));
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
